vector_sweep_capture: RTL and testbench

upstream stimulus and response-capture stage for the 4-input / 3-output combinational block. It drives A..D through all 16 combinations and captures Falpha/Fbeta/Fgamma for each one.

Interface
REQ-001 Parameter DWELL, default 4, meaning clock cycles each vector is held (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  sweep request, sampled on rising edge.
REQ-005 A, B, C, D  output  1 each  stimulus vector to the combinational block.
REQ-006 Falpha, Fbeta, Fgamma  input  1 each  responses from the combinational block.
REQ-007 busy  output  1  high while a sweep is in progress.
REQ-008 done  output  1  one-cycle pulse marking sweep completion.
REQ-009 idx  output  4  index of the current vector.
REQ-010 resp  output  48  captured response table.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-012 {A,B,C,D} SHALL equal idx, with A as MSB, in every state.
REQ-013 In IDLE, start=1 at an edge SHALL load RUN, set idx=0, set dwell count=0 and clear resp to 0.
REQ-014 start SHALL be ignored in RUN and DONE; a request is never queued.
REQ-015 In RUN, the dwell counter SHALL increment each cycle.
REQ-016 At the edge where dwell count=DWELL-1, the block SHALL write {Falpha,Fbeta,Fgamma} into resp[3*idx+2 : 3*idx], with Falpha as MSB.
REQ-017 On that same edge, if idx<15 the block SHALL increment idx and set dwell count=0; if idx=15 it SHALL go to DONE with idx held at 15.
REQ-018 Each vector SHALL be stable for exactly DWELL cycles, and responses SHALL be sampled DWELL-1 cycles after the vector is applied.
REQ-019 busy SHALL be 1 exactly while in RUN.
REQ-020 done SHALL be 1 exactly while in DONE, which lasts one cycle and then unconditionally goes to IDLE.
REQ-021 On the DONE-to-IDLE edge, idx SHALL return to 0.
REQ-022 resp SHALL hold its value from DONE until the next accepted start or reset.
REQ-023 Latency: if start is accepted at edge k, busy SHALL rise after edge k, done SHALL be high in the cycle after edge k+16*DWELL, and IDLE SHALL be re-entered at edge k+16*DWELL+1.
REQ-024 Only resp slot idx SHALL be written per sample; all other slots are unchanged.
REQ-025 The dwell counter SHALL be 8 bits and SHALL never exceed DWELL-1 (no wrap).

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force: state=IDLE, idx=0, A..D=0, dwell count=0, resp=0, busy=0, done=0.
REQ-027 Reset asserted mid-RUN SHALL abort the sweep with no done pulse; a new start is required after release.
REQ-028 Outputs SHALL hold reset values while rst=1, and start SHALL be ignored while rst=1.
REQ-029 The first edge after rst falls SHALL be able to accept start.

Verification
REQ-030 Bench model is Falpha=A^B, Fbeta=C&D, Fgamma=1; with DWELL=4, pulse start -> the bench SHALL check all of the following:
- busy high for 64 cycles;
- done pulses once, in the cycle after edge k+64;
- resp[2:0]=3'b001, resp[11:9]=3'b011, resp[14:12]=3'b101, resp[47:45]=3'b011.
REQ-031 Tie F inputs to 1, sweep -> resp=48'hFFFF_FFFF_FFFF; then tie F inputs to 0 and sweep again -> resp=48'h0 (start clears prior table).
REQ-032 Assert rst during RUN at idx=7 -> all outputs zero immediately; no done pulse; resp=0.
REQ-033 Pulse start repeatedly during RUN and during DONE -> exactly one sweep of 16*DWELL cycles and one done pulse.
REQ-034 DWELL=2 boundary -> {A,B,C,D} steps 0000 to 1111 every 2 cycles; each slot is sampled on the vector's second cycle.
REQ-035 Hold start high continuously -> back-to-back sweeps separated by exactly one DONE cycle and one IDLE-accept edge.

---
 rtl/vector_sweep_capture.sv | 115 +++++++++++
 tb/tb_vector_sweep_capture.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/vector_sweep_capture.sv
// vector_sweep_capture
//   Stimulus and response-capture stage for a 4-input / 3-output
//   combinational block. A sweep drives {A,B,C,D} through 0..15. Each vector
//   is held for DWELL cycles, and the responses are captured at the end of
//   that dwell.
//
// Parameters
//   DWELL   cycles each vector is held (2..255)
//
// Ports
//   clk                   single clock, rising edge
//   rst                   asynchronous active-high reset
//   start                 sweep request, only honoured in IDLE
//   A,B,C,D               stimulus vector, equal to idx (A is the MSB)
//   Falpha,Fbeta,Fgamma   responses from the combinational block
//   busy                  high while a sweep is running
//   done                  one-cycle pulse after the last vector is captured
//   idx                   index of the current vector
//   resp                  captured table, slot i = resp[3*i+2:3*i] = {Fa,Fb,Fg}
module vector_sweep_capture #(
   parameter int DWELL = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        A,
   output logic        B,
   output logic        C,
   output logic        D,
   input  logic        Falpha,
   input  logic        Fbeta,
   input  logic        Fgamma,
   output logic        busy,
   output logic        done,
   output logic [3:0]  idx,
   output logic [47:0] resp
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Last dwell count of a vector; the capture happens on this edge.
   localparam logic [7:0] LAST = 8'(DWELL - 1);

   state_t      state, state_n;
   logic [3:0]  idx_n;
   logic [7:0]  cnt, cnt_n;
   logic [47:0] resp_n;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= 4'd0;
         cnt   <= 8'd0;
         resp  <= 48'd0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         cnt   <= cnt_n;
         resp  <= resp_n;
      end
   end

   always_comb begin
      state_n = state;
      idx_n   = idx;
      cnt_n   = cnt;
      resp_n  = resp;
      unique case (state)
         IDLE: begin
            if (start) begin
               state_n = RUN;
               idx_n   = 4'd0;
               cnt_n   = 8'd0;
               resp_n  = 48'd0;
            end
         end
         RUN: begin
            if (cnt == LAST) begin
               // Only the slot belonging to the current vector is written.
               for (int s = 0; s < 16; s++) begin
                  if (idx == 4'(s)) begin
                     resp_n[3*s +: 3] = {Falpha, Fbeta, Fgamma};
                  end
               end
               if (idx == 4'd15) begin
                  state_n = DONE;
               end else begin
                  idx_n = idx + 4'd1;
                  cnt_n = 8'd0;
               end
            end else begin
               cnt_n = cnt + 8'd1;
            end
         end
         DONE: begin
            // A single cycle; a start seen here is dropped, not queued.
            state_n = IDLE;
            idx_n   = 4'd0;
            cnt_n   = 8'd0;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign {A, B, C, D} = idx;
   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule

// File: tb/tb_vector_sweep_capture.sv
module tb_vector_sweep_capture;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        sel;      // 0: DWELL=4 instance, 1: DWELL=2 instance
   logic        glitch;   // invert responses except on the vector's last cycle
   logic [2:0]  tbl [16];

   logic        a1, b1, c1, d1, busy1, done1;
   logic [3:0]  idx1;
   logic [47:0] resp1;
   logic [2:0]  f1;
   logic        a2, b2, c2, d2, busy2, done2;
   logic [3:0]  idx2;
   logic [47:0] resp2;
   logic [2:0]  f2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   vector_sweep_capture #(.DWELL(4)) dut1 (
      .clk(clk), .rst(rst), .start(start & ~sel),
      .A(a1), .B(b1), .C(c1), .D(d1),
      .Falpha(f1[2]), .Fbeta(f1[1]), .Fgamma(f1[0]),
      .busy(busy1), .done(done1), .idx(idx1), .resp(resp1)
   );

   vector_sweep_capture #(.DWELL(2)) dut2 (
      .clk(clk), .rst(rst), .start(start & sel),
      .A(a2), .B(b2), .C(c2), .D(d2),
      .Falpha(f2[2]), .Fbeta(f2[1]), .Fgamma(f2[0]),
      .busy(busy2), .done(done2), .idx(idx2), .resp(resp2)
   );

   // Selected-instance views used by the sweep checker.
   logic        busy_s, done_s;
   logic [3:0]  idx_s, abcd_s;
   logic [47:0] resp_s;
   assign busy_s = sel ? busy2 : busy1;
   assign done_s = sel ? done2 : done1;
   assign idx_s  = sel ? idx2 : idx1;
   assign abcd_s = sel ? {a2, b2, c2, d2} : {a1, b1, c1, d1};
   assign resp_s = sel ? resp2 : resp1;

   // Combinational block model: the response is correct only on the last
   // cycle of each vector's dwell, so a capture at the wrong cycle is visible.
   int         age1 = 0, age2 = 0;
   logic [3:0] lv1 = 4'd0, lv2 = 4'd0;
   logic       lb1 = 1'b0, lb2 = 1'b0;
   always @(negedge clk) begin
      if ({a1, b1, c1, d1} != lv1 || (busy1 && !lb1)) age1 <= 0;
      else if (age1 < 255) age1 <= age1 + 1;
      lv1 <= {a1, b1, c1, d1};
      lb1 <= busy1;
      if ({a2, b2, c2, d2} != lv2 || (busy2 && !lb2)) age2 <= 0;
      else if (age2 < 255) age2 <= age2 + 1;
      lv2 <= {a2, b2, c2, d2};
      lb2 <= busy2;
   end
   assign f1 = (glitch && age1 != 3) ? ~tbl[{a1, b1, c1, d1}] : tbl[{a1, b1, c1, d1}];
   assign f2 = (glitch && age2 != 1) ? ~tbl[{a2, b2, c2, d2}] : tbl[{a2, b2, c2, d2}];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] expected_table();
      logic [47:0] r;
      for (int i = 0; i < 16; i++) r[3*i +: 3] = tbl[i];
      return r;
   endfunction

   task automatic fill_model();
      for (int v = 0; v < 16; v++) begin
         logic [3:0] x;
         x = 4'(v);
         tbl[v] = {x[3] ^ x[2], x[1] & x[0], 1'b1};
      end
   endtask

   task automatic fill_const(input logic [2:0] val);
      for (int v = 0; v < 16; v++) tbl[v] = val;
   endtask

   task automatic fill_random();
      for (int v = 0; v < 16; v++) tbl[v] = 3'($urandom_range(0, 7));
   endtask

   // One sweep, entered just after a negedge. mode 0: single start pulse,
   // 1: start toggled randomly through RUN and forced high in DONE,
   // 2: start held high (ends in the IDLE cycle ahead of the next accept).
   task automatic run_sweep(input int mode);
      int dw, last, busy_n, done_n, done_at, bad, ei;
      logic [47:0] exp;
      exp     = expected_table();
      dw      = sel ? 2 : 4;
      last    = (mode == 2) ? 16*dw + 2 : 16*dw + 3;
      busy_n  = 0;
      done_n  = 0;
      done_at = -1;
      bad     = 0;
      start   = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= last; n++) begin
         @(negedge clk);
         if (n == 1) chk("resp_cleared_on_start", resp_s, 48'd0);
         if (n <= 16*dw) ei = (n - 1) / dw;
         else if (n == 16*dw + 1) ei = 15;
         else ei = 0;
         if (busy_s) busy_n++;
         if (done_s) begin
            done_n++;
            done_at = n;
         end
         if (busy_s != (n <= 16*dw)) bad++;
         if (idx_s != 4'(ei) || abcd_s != idx_s) bad++;
         if (mode == 0) start = 1'b0;
         else if (mode == 1) start = (n <= 16*dw) ? 1'($urandom_range(0, 1)) : (n == 16*dw + 1);
         else start = 1'b1;
      end
      chk("busy_cycles", busy_n, 16*dw);
      chk("done_pulses", done_n, 1);
      chk("done_cycle", done_at, 16*dw + 1);
      chk("trace_errors", bad, 0);
      chk("resp_table", resp_s, exp);
   endtask

   initial begin
      int busy_n, done_n, waited;
      rst    = 1'b1;
      start  = 1'b0;
      sel    = 1'b0;
      glitch = 1'b0;
      fill_const(3'd0);
      #1;
      chk("rst_busy", busy1, 0);
      chk("rst_done", done1, 0);
      chk("rst_idx", idx1, 0);
      chk("rst_abcd", {a1, b1, c1, d1}, 0);
      chk("rst_resp", resp1, 0);
      chk("rst2_state", {busy2, done2, idx2, resp2}, 0);
      @(negedge clk);
      rst = 1'b0;

      // Reference function sweep and the named table slots.
      glitch = 1'b1;
      fill_model();
      run_sweep(0);
      chk("slot0", resp1[2:0], 3'b001);
      chk("slot3", resp1[11:9], 3'b011);
      chk("slot4", resp1[14:12], 3'b101);
      chk("slot15", resp1[47:45], 3'b011);

      // Constant responses; the second sweep must clear the all-ones table.
      glitch = 1'b0;
      fill_const(3'b111);
      run_sweep(0);
      chk("all_ones", resp1, 48'hFFFF_FFFF_FFFF);
      fill_const(3'b000);
      run_sweep(0);
      chk("all_zeros", resp1, 48'h0);

      // Random tables with repeated start requests in RUN and DONE.
      glitch = 1'b1;
      fill_random();
      run_sweep(1);

      // start held high: back-to-back sweeps.
      fill_random();
      run_sweep(2);
      fill_random();
      run_sweep(2);
      fill_random();
      run_sweep(0);

      // Reset in the middle of a sweep at idx 7.
      fill_model();
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start  = 1'b0;
      waited = 0;
      while (idx1 != 4'd7 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      chk("reach_idx7", idx1, 7);
      rst = 1'b1;
      #1;
      chk("midrun_rst_busy", busy1, 0);
      chk("midrun_rst_idx_abcd", {idx1, a1, b1, c1, d1}, 0);
      chk("midrun_rst_resp", resp1, 0);
      chk("midrun_rst_done", done1, 0);
      start = 1'b1;
      repeat (3) @(negedge clk);
      chk("start_ignored_in_rst", {busy1, done1}, 0);
      rst    = 1'b0;
      start  = 1'b0;
      busy_n = 0;
      done_n = 0;
      repeat (80) begin
         @(negedge clk);
         if (busy1) busy_n++;
         if (done1) done_n++;
      end
      chk("no_resume_busy", busy_n, 0);
      chk("no_done_after_abort", done_n, 0);
      chk("resp_after_abort", resp1, 0);

      // start accepted on the first edge after reset release.
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      fill_random();
      run_sweep(0);

      // DWELL=2 instance.
      sel = 1'b1;
      @(negedge clk);
      fill_random();
      run_sweep(0);
      fill_model();
      run_sweep(1);
      chk("d2_slot4", resp2[14:12], 3'b101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
